// File: rtl/wordle_guess_eval.sv
// Wordle guess collector and two-pass grader.
// Letters are collected into a 5-slot buffer. On submit, the buffer is graded against a
// latched copy of the target word. The first pass marks greens and the second marks yellows.
module wordle_guess_eval #(
  parameter int unsigned LETTER_W = 5,
  parameter int unsigned WORD_LEN = 5
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic [LETTER_W*WORD_LEN-1:0] target_word,
  input  logic [LETTER_W-1:0]          letter_in,
  input  logic                         letter_valid,
  input  logic                         backspace,
  input  logic                         submit,
  output logic [LETTER_W*WORD_LEN-1:0] guess_word,
  output logic [2:0]                   letter_count,
  output logic                         busy,
  output logic                         result_valid,
  output logic [2*WORD_LEN-1:0]        colors,
  output logic                         win,
  output logic                         invalid_len
);

  localparam logic [2:0]          FullCnt = 3'(WORD_LEN);
  localparam logic [2:0]          LastIdx = 3'(WORD_LEN - 1);
  localparam logic [LETTER_W-1:0] MaxCode = LETTER_W'(25);
  localparam logic [1:0]          ColGray   = 2'b00;
  localparam logic [1:0]          ColYellow = 2'b01;
  localparam logic [1:0]          ColGreen  = 2'b10;

  typedef enum logic [1:0] {StCollect, StGreen, StYellow, StDone} state_e;

  state_e                                state_q;
  logic [2:0]                            idx_q;
  logic [2:0]                            count_q;
  logic [WORD_LEN-1:0][LETTER_W-1:0]     guess_q;
  logic [WORD_LEN-1:0][LETTER_W-1:0]     target_q;
  logic [WORD_LEN-1:0]                   used_q;
  logic [WORD_LEN-1:0][1:0]              work_q;
  logic [2*WORD_LEN-1:0]                 colors_q;
  logic                                  win_q;
  logic                                  result_valid_q;
  logic                                  invalid_len_q;

  logic       green_hit;
  logic       yel_found;
  logic [2:0] yel_j;
  logic       all_green;

  // Per-cycle grading helpers: green match at idx, lowest unused matching target slot, win.
  always_comb begin
    green_hit = (guess_q[idx_q] == target_q[idx_q]);
    yel_found = 1'b0;
    yel_j     = 3'd0;
    // Descending scan so the lowest matching slot is the one that sticks.
    for (int j = WORD_LEN - 1; j >= 0; j--) begin
      if (!used_q[j] && (target_q[j] == guess_q[idx_q])) begin
        yel_found = 1'b1;
        yel_j     = 3'(j);
      end
    end
    all_green = 1'b1;
    for (int k = 0; k < WORD_LEN; k++) begin
      if (work_q[k] != ColGreen) all_green = 1'b0;
    end
  end

  // Main FSM: collection, green pass, yellow pass, result publication.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q        <= StCollect;
      idx_q          <= 3'd0;
      count_q        <= 3'd0;
      guess_q        <= '0;
      target_q       <= '0;
      used_q         <= '0;
      work_q         <= '0;
      colors_q       <= '0;
      win_q          <= 1'b0;
      result_valid_q <= 1'b0;
      invalid_len_q  <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      invalid_len_q  <= 1'b0;
      unique case (state_q)
        StCollect: begin
          if (backspace) begin
            if (count_q != 3'd0) begin
              guess_q[count_q - 3'd1] <= '0;
              count_q                 <= count_q - 3'd1;
            end
          end else if (submit) begin
            if (count_q == FullCnt) begin
              target_q <= target_word;
              used_q   <= '0;
              work_q   <= '0;
              idx_q    <= 3'd0;
              state_q  <= StGreen;
            end else begin
              invalid_len_q <= 1'b1;
            end
          end else if (letter_valid && (count_q < FullCnt) && (letter_in <= MaxCode)) begin
            guess_q[count_q] <= letter_in;
            count_q          <= count_q + 3'd1;
          end
        end
        StGreen: begin
          // Working colours start gray, so only a hit needs writing.
          if (green_hit) begin
            work_q[idx_q] <= ColGreen;
            used_q[idx_q] <= 1'b1;
          end
          if (idx_q == LastIdx) begin
            idx_q   <= 3'd0;
            state_q <= StYellow;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StYellow: begin
          if ((work_q[idx_q] == ColGray) && yel_found) begin
            work_q[idx_q] <= ColYellow;
            used_q[yel_j] <= 1'b1;
          end
          if (idx_q == LastIdx) begin
            idx_q   <= 3'd0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StDone: begin
          colors_q       <= work_q;
          win_q          <= all_green;
          result_valid_q <= 1'b1;
          guess_q        <= '0;
          count_q        <= 3'd0;
          state_q        <= StCollect;
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign guess_word   = guess_q;
  assign letter_count = count_q;
  assign busy         = (state_q != StCollect);
  assign result_valid = result_valid_q;
  assign colors       = colors_q;
  assign win          = win_q;
  assign invalid_len  = invalid_len_q;

endmodule

// File: tb/tb_wordle_guess_eval.sv
// Bench for wordle_guess_eval: directed vectors, expected results queued per submit and
// checked by an independent monitor whenever result_valid is seen.
module tb_wordle_guess_eval;

  logic        Clk = 1'b0;
  logic        reset;
  logic [24:0] target_word;
  logic [4:0]  letter_in;
  logic        letter_valid, backspace, submit;
  logic [24:0] guess_word;
  logic [2:0]  letter_count;
  logic        busy, result_valid, win, invalid_len;
  logic [9:0]  colors;

  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];  // {win, colors}

  wordle_guess_eval dut (
    .Clk          (Clk),
    .reset        (reset),
    .target_word  (target_word),
    .letter_in    (letter_in),
    .letter_valid (letter_valid),
    .backspace    (backspace),
    .submit       (submit),
    .guess_word   (guess_word),
    .letter_count (letter_count),
    .busy         (busy),
    .result_valid (result_valid),
    .colors       (colors),
    .win          (win),
    .invalid_len  (invalid_len)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] w5(input int a, input int b, input int c, input int d,
                                     input int e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic put_letter(input logic [4:0] l);
    letter_in    = l;
    letter_valid = 1'b1;
    tick();
    letter_valid = 1'b0;
  endtask

  task automatic do_backspace();
    backspace = 1'b1;
    tick();
    backspace = 1'b0;
  endtask

  task automatic do_submit();
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) put_letter(w[5*i +: 5]);
  endtask

  // Bounded wait for result_valid; n is edges counted after the current point.
  task automatic wait_result(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!result_valid && n < 30);
    if (!result_valid) begin
      fails++;
      tests++;
      $display("FAIL result_timeout: got no result_valid, expected one within 30 cycles");
    end
  endtask

  // Scoreboard monitor: every result must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!reset && result_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got colors %b win %b, expected no result", colors, win);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("colors", 32'(colors), 32'(e[9:0]));
        check("win", 32'(win), 32'(e[10]));
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; target_word = '0; letter_in = '0;
    letter_valid = 1'b0; backspace = 1'b0; submit = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_guess", 32'(guess_word), 0);
    check("rst_count", 32'(letter_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_colors", 32'(colors), 0);
    check("rst_win", 32'(win), 0);
    check("rst_invalid", 32'(invalid_len), 0);

    // 1. CRANE vs CRANE: all green, 11-cycle latency
    target_word = w5(2, 17, 0, 13, 4);
    type_word(w5(2, 17, 0, 13, 4));
    check("t1_count", 32'(letter_count), 5);
    check("t1_guess", 32'(guess_word), 32'(w5(2, 17, 0, 13, 4)));
    exp_q.push_back({1'b1, 10'b1010101010});
    do_submit();
    check("t1_busy", 32'(busy), 1);
    wait_result(n);
    check("t1_latency", 32'(n), 11);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_count_after", 32'(letter_count), 0);
    check("t1_guess_after", 32'(guess_word), 0);

    // 5. Reset at edge+6 aborts grading; no result
    type_word(w5(0, 1, 2, 3, 4));
    do_submit();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_colors", 32'(colors), 0);
    check("t5_win", 32'(win), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_count", 32'(letter_count), 0);
    check("t5_guess", 32'(guess_word), 0);
    repeat (15) tick();

    // 2. ABBEY vs BABBY: duplicate B at pos3 stays gray
    target_word = w5(0, 1, 1, 4, 24);
    type_word(w5(1, 0, 1, 1, 24));
    exp_q.push_back({1'b0, 10'b10_00_10_01_01});
    do_submit();
    wait_result(n);

    // 3. Backspace handling
    put_letter(5'd0);
    put_letter(5'd1);
    check("t3_count2", 32'(letter_count), 2);
    do_backspace();
    check("t3_count1", 32'(letter_count), 1);
    do_backspace();
    check("t3_count0", 32'(letter_count), 0);
    do_backspace();
    check("t3_count0b", 32'(letter_count), 0);
    check("t3_guess", 32'(guess_word), 0);
    put_letter(5'd0);
    backspace = 1'b1; letter_valid = 1'b1; letter_in = 5'd2;
    tick();
    backspace = 1'b0; letter_valid = 1'b0;
    check("t3_bs_wins_count", 32'(letter_count), 0);
    check("t3_bs_wins_guess", 32'(guess_word), 0);

    // 4. Short submit, invalid code, sixth letter, pulses while busy
    put_letter(5'd2); put_letter(5'd0); put_letter(5'd19);
    do_submit();
    check("t4_invalid", 32'(invalid_len), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_count", 32'(letter_count), 3);
    check("t4_guess", 32'(guess_word), 32'({5'd0, 5'd0, 5'd19, 5'd0, 5'd2}));
    tick();
    check("t4_invalid_pulse", 32'(invalid_len), 0);
    put_letter(5'd27);
    check("t4_code27", 32'(letter_count), 3);
    put_letter(5'd3); put_letter(5'd4);
    put_letter(5'd5);
    check("t4_sixth_count", 32'(letter_count), 5);
    check("t4_sixth_guess", 32'(guess_word), 32'(w5(2, 0, 19, 3, 4)));
    target_word = w5(2, 17, 0, 13, 4);
    exp_q.push_back({1'b0, 10'b10_00_00_01_10});
    do_submit();
    do_backspace();
    put_letter(5'd7);
    do_submit();
    wait_result(n);
    check("t4_count_after", 32'(letter_count), 0);

    // 6. ZZZZZ vs AAAAA: all gray; target change while busy ignored
    target_word = w5(25, 25, 25, 25, 25);
    type_word(w5(0, 0, 0, 0, 0));
    exp_q.push_back({1'b0, 10'b0});
    do_submit();
    target_word = '0;
    wait_result(n);

    repeat (20) tick();
    check("all_results_seen", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
